// File: rtl/k051962_tile_shifter_if.sv
// Pixel-path bundle between the tile layer generator, the k051962 serializer and the layer mixer.
// The master side drives the tile word, attribute and strobes; the slave side returns pixels.
interface k051962_tile_shifter_if #(
  parameter int PAL_BITS = 4,
  parameter int FINE_W   = 3
) ();
  logic                  PIX_EN;
  logic                  LOAD;
  logic [31:0]           ROMD;
  logic [7:0]            COL;
  logic [FINE_W-1:0]     FINE;
  logic                  BLANK;
  logic [PAL_BITS+3:0]   PIX_OUT;
  logic                  OPAQUE;
  logic                  UNDERRUN;

  modport master (
    output PIX_EN, LOAD, ROMD, COL, FINE, BLANK,
    input  PIX_OUT, OPAQUE, UNDERRUN
  );

  modport slave (
    input  PIX_EN, LOAD, ROMD, COL, FINE, BLANK,
    output PIX_OUT, OPAQUE, UNDERRUN
  );
endinterface

// File: rtl/k051962_tile_shifter.sv
// Serializes one planar 32-bit tile row into 4bpp pixels per strobe, applies 0..2**FINE_W-1
// pixels of fine horizontal scroll through a tapped delay line, and flags shifter underrun.
module k051962_tile_shifter #(
  parameter int PAL_BITS = 4,
  parameter int FINE_W   = 3
) (
  input  logic                         M24,
  input  logic                         RES,
  k051962_tile_shifter_if.slave        bus
);
  localparam int DEPTH = 2 ** FINE_W;
  localparam int PW    = PAL_BITS + 4;

  logic [3:0]          slot [8];
  logic [PAL_BITS-1:0] pal;
  logic [3:0]          cnt;
  logic [PW-1:0]       dly [DEPTH-1];
  logic [PW-1:0]       pix_out_q;
  logic                opaque_q;
  logic                underrun_q;

  logic [3:0]          pix_row [8];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tap_sel;
  logic [PW-1:0]       out_nxt;
  logic                unused_col;

  assign unused_col = ^bus.COL[3:1];

  // pix_row[n] gathers bit n of each bitplane; n = 7 is the leftmost pixel.
  always_comb begin
    for (int n = 0; n < 8; n++) begin
      pix_row[n] = {bus.ROMD[24+n], bus.ROMD[16+n], bus.ROMD[8+n], bus.ROMD[n]};
    end
  end

  assign head = {pal, slot[0]};

  always_comb begin
    tap_sel = head;
    for (int i = 1; i < DEPTH; i++) begin
      if (bus.FINE == i[FINE_W-1:0]) tap_sel = dly[i-1];
    end
  end

  assign out_nxt = bus.BLANK ? '0 : tap_sel;

  always_ff @(posedge M24) begin
    if (RES) begin
      for (int k = 0; k < 8; k++) slot[k] <= '0;
      for (int i = 0; i < DEPTH - 1; i++) dly[i] <= '0;
      pal        <= '0;
      cnt        <= '0;
      pix_out_q  <= '0;
      opaque_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else if (bus.PIX_EN) begin
      if (bus.LOAD) begin
        for (int k = 0; k < 8; k++) begin
          slot[k] <= bus.COL[0] ? pix_row[k] : pix_row[7-k];
        end
        pal <= bus.COL[7 -: PAL_BITS];
        cnt <= '0;
      end else begin
        for (int k = 0; k < 7; k++) slot[k] <= slot[k+1];
        slot[7] <= '0;
        if (cnt != 4'd8) cnt <= cnt + 4'd1;
        // Eighth pixel consumed with no reload pending: sticky until reset.
        if (cnt == 4'd7) underrun_q <= 1'b1;
      end
      dly[0] <= head;
      for (int i = 1; i < DEPTH - 1; i++) dly[i] <= dly[i-1];
      pix_out_q <= out_nxt;
      opaque_q  <= (out_nxt[3:0] != 4'd0);
    end
  end

  assign bus.PIX_OUT  = pix_out_q;
  assign bus.OPAQUE   = opaque_q;
  assign bus.UNDERRUN = underrun_q;
endmodule

// File: tb/tb_k051962_tile_shifter.sv
// Directed bench for k051962_tile_shifter: a table of per-strobe vectors with hand-computed
// pixels, plus hand-written sequences for fine scroll, blanking, strobe gating and mid-line reset.
module tb_k051962_tile_shifter;
  logic M24;
  logic RES;

  k051962_tile_shifter_if #(.PAL_BITS(4), .FINE_W(3)) bus ();

  k051962_tile_shifter #(.PAL_BITS(4), .FINE_W(3)) dut (
    .M24 (M24),
    .RES (RES),
    .bus (bus)
  );

  initial M24 = 1'b0;
  always #5 M24 = ~M24;

  typedef struct {
    bit          rst;
    bit          load;
    logic [31:0] romd;
    logic [7:0]  col;
    logic [2:0]  fine;
    bit          blank;
    logic [7:0]  exp_pix;
    bit          exp_und;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void add(bit rst, bit load, logic [31:0] romd, logic [7:0] col,
                              logic [2:0] fine, bit blank, logic [7:0] exp_pix, bit exp_und);
    vec_t v;
    v.rst = rst; v.load = load; v.romd = romd; v.col = col; v.fine = fine;
    v.blank = blank; v.exp_pix = exp_pix; v.exp_und = exp_und;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_pix(input string name, input logic [7:0] exp_pix, input bit exp_und);
    check({name, " pix"}, bus.PIX_OUT, exp_pix);
    check({name, " opq"}, bus.OPAQUE, exp_pix[3:0] != 4'd0);
    check({name, " und"}, bus.UNDERRUN, exp_und);
  endtask

  task automatic do_reset();
    @(negedge M24);
    RES = 1'b1;
    repeat (2) begin
      bus.PIX_EN = 1'($urandom); bus.LOAD = 1'($urandom); bus.ROMD = $urandom;
      bus.COL = 8'($urandom); bus.FINE = 3'($urandom); bus.BLANK = 1'($urandom);
      @(negedge M24);
    end
    RES = 1'b0;
    bus.PIX_EN = 1'b0; bus.LOAD = 1'b0; bus.BLANK = 1'b0; bus.FINE = 3'd0;
  endtask

  task automatic strobe(input bit ld, input logic [31:0] rd, input logic [7:0] cl,
                        input logic [2:0] fn, input bit bl);
    @(negedge M24);
    bus.PIX_EN = 1'b1; bus.LOAD = ld; bus.ROMD = rd; bus.COL = cl;
    bus.FINE = fn; bus.BLANK = bl;
    @(negedge M24);
    bus.PIX_EN = 1'b0; bus.LOAD = 1'b0;
  endtask

  initial begin
    RES = 1'b0;
    bus.PIX_EN = 1'b0; bus.LOAD = 1'b0; bus.ROMD = '0; bus.COL = '0;
    bus.FINE = '0; bus.BLANK = 1'b0;

    // Reset, then a non-load strobe still shows transparent.
    add(1, 0, 0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0, 0, 0, 0, 8'h00, 0);
    // Leftmost-pixel order, FINE=0.
    add(0, 1, 32'h0000_0080, 8'h50, 0, 0, 8'h00, 0);
    add(0, 0, 0, 0, 0, 0, 8'h51, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 0, 0, 0, 8'h50, 0);
    add(0, 0, 0, 0, 0, 0, 8'h50, 1);
    // FLIPX: the set pixel arrives last.
    add(1, 0, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 32'h0000_0080, 8'h51, 0, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 8'h50, 0);
    add(0, 0, 0, 0, 0, 0, 8'h51, 1);
    // Seamless back-to-back tiles, then one skipped reload.
    add(1, 0, 0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 32'hFFFF_FFFF, 8'hA0, 0, 0, 8'h00, 0);
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 8'hAF, 0);
      add(0, 1, 32'hFFFF_FFFF, 8'hA0, 0, 0, 8'hAF, 0);
    end
    for (int i = 0; i < 7; i++) add(0, 0, 0, 0, 0, 0, 8'hAF, 0);
    add(0, 0, 0, 0, 0, 0, 8'hAF, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 0, 0, 0, 8'hA0, 1);
    add(0, 1, 32'hFFFF_FFFF, 8'hA0, 0, 0, 8'hA0, 1);
    add(0, 0, 0, 0, 0, 0, 8'hAF, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      else strobe(vecs[i].load, vecs[i].romd, vecs[i].col, vecs[i].fine, vecs[i].blank);
      check_pix($sformatf("vec%0d", i), vecs[i].exp_pix, vecs[i].exp_und);
    end

    // Fine scroll: the set pixel arrives FINE strobes later than with FINE=0.
    for (int f = 3; f <= 7; f += 4) begin
      do_reset();
      strobe(1, 32'h0000_0080, 8'h50, 3'(f), 0);
      for (int k = 1; k <= 8; k++) begin
        strobe(0, 0, 8'h50, 3'(f), 0);
        check(
          $sformatf("fine%0d k%0d pix", f, k), bus.PIX_OUT,
          (k < 1 + f) ? 8'h00 : ((k == 1 + f) ? 8'h51 : 8'h50));
      end
    end

    // Blanking hides pixels but the shifter keeps its phase (row 1,0,0,1,1,0,0,0).
    do_reset();
    strobe(1, 32'h0000_0098, 8'hA0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      strobe(0, 0, 8'hA0, 0, 1);
      check_pix($sformatf("blank k%0d", k), 8'h00, 0);
    end
    strobe(0, 0, 8'hA0, 0, 0);
    check_pix("unblank k4", 8'hA1, 0);
    strobe(0, 0, 8'hA0, 0, 0);
    check_pix("unblank k5", 8'hA1, 0);
    strobe(0, 0, 8'hA0, 0, 0);
    check_pix("unblank k6", 8'hA0, 0);

    // LOAD without PIX_EN is ignored.
    do_reset();
    strobe(1, 32'h0000_0098, 8'hA0, 0, 0);
    strobe(0, 0, 8'hA0, 0, 0);
    check_pix("gate p7", 8'hA1, 0);
    @(negedge M24);
    bus.LOAD = 1'b1; bus.ROMD = 32'hFFFF_FFFF; bus.COL = 8'h30;
    @(negedge M24);
    bus.LOAD = 1'b0;
    check_pix("gate hold", 8'hA1, 0);
    strobe(0, 0, 8'h30, 0, 0);
    check_pix("gate p6", 8'hA0, 0);
    strobe(0, 0, 8'h30, 0, 0);
    check_pix("gate p5", 8'hA0, 0);
    strobe(0, 0, 8'h30, 0, 0);
    check_pix("gate p4", 8'hA1, 0);

    // Reset mid-line: transparent until the next load, which restarts cleanly.
    do_reset();
    strobe(1, 32'hFFFF_FFFF, 8'hA0, 0, 0);
    strobe(0, 0, 0, 0, 0);
    strobe(0, 0, 0, 0, 0);
    check_pix("midline pre", 8'hAF, 0);
    do_reset();
    check_pix("midline rst", 8'h00, 0);
    strobe(0, 0, 0, 0, 0);
    check_pix("midline idle", 8'h00, 0);
    strobe(1, 32'hFFFF_FFFF, 8'hA0, 0, 0);
    check_pix("midline load", 8'h00, 0);
    strobe(0, 0, 0, 0, 0);
    check_pix("midline first", 8'hAF, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
